motion_highlight: RTL and testbench
===================================

// Module: motion_highlight
// PURPOSE
// Final stage of the motion-detect pipeline, directly upstream of the output FIFO drained by the top level.
// Joins the binary motion mask from the subtract/threshold stage with the second frame stream, pixel for pixel.
// Masked pixels are replaced by a highlight colour; unmasked pixels pass through unchanged.
// Counts pixels per frame, pulses frame_done at end of frame, and reports the number of motion pixels.
// PARAMETERS
// WIDTH       720           image width in pixels
// HEIGHT      540           image height in pixels
// HL_COLOR    32'h0000FF00  replacement pixel {B,G,R,8'h00}; default is pure red
// CNT_W       20            counter width; must satisfy 2**CNT_W > WIDTH*HEIGHT
// PORTS
// clk           in   1      system clock, rising edge
// reset         in   1      asynchronous, active-high reset
// mask_rd_en    out  1      pop mask FIFO (FWFT)
// mask_dout     in   8      mask byte; nonzero = motion
// mask_empty    in   1      mask FIFO empty
// frame_rd_en   out  1      pop frame FIFO (FWFT)
// frame_dout    in   32     frame pixel {B,G,R,8'h00}
// frame_empty   in   1      frame FIFO empty
// out_wr_en     out  1      push to output FIFO
// out_din       out  32     output pixel {B,G,R,8'h00}
// out_full      in   1      output FIFO full
// frame_done    out  1      one-cycle pulse when last pixel of frame is written
// motion_count  out  CNT_W  motion pixels in last completed frame
// BEHAVIOUR
// - One clock domain; clock is clk; reset is asynchronous, active-high. Reset clears every register:
//   out_valid=0, out_din=0, pix_cnt=0, run_cnt=0, motion_count=0, frame_done=0.
// - Input FIFOs are first-word-fall-through: dout is valid whenever !empty; rd_en pops that word.
// - One-entry output register (out_valid, out_din). out_wr_en = out_valid & !out_full (combinational).
// - accept = !mask_empty & !frame_empty & (!out_valid | !out_full).
// - mask_rd_en = frame_rd_en = accept. Both FIFOs are always popped together; never pop one alone.
// - On accept: out_din <= (mask_dout != 0) ? HL_COLOR : frame_dout; out_valid <= 1.
// - If out_wr_en & !accept: out_valid <= 0. If out_valid & out_full: hold out_din, out_valid unchanged.
// - Latency: input pop to out_wr_en = 1 cycle when out_full=0. Throughput: 1 pixel/cycle sustained.
// - Back-pressure: data is never dropped or duplicated while out_full is high; the held pixel is written
//   on the first cycle out_full drops, and a new pixel may be accepted in that same cycle.
// - Counters advance on out_wr_en (a committed write), not on accept:
//   pix_cnt += 1; run_cnt += (written pixel was masked). A per-entry mask flag is registered alongside out_din.
// - End of frame: on the out_wr_en where pix_cnt == WIDTH*HEIGHT-1: pix_cnt <= 0; run_cnt <= 0;
//   motion_count <= run_cnt + masked_bit; frame_done <= 1 for exactly that cycle (registered, visible next cycle).
// - Frames are back-to-back. No idle gap is needed. The next frame's first pixel may be written in the
//   cycle after the last pixel of the previous frame.
// - motion_count holds its value until the next frame completes.
// - Reset mid-frame: partial counts are discarded. The in-flight output pixel is lost. Upstream FIFOs
//   are reset by the top level at the same time.
// - An empty input FIFO stalls both streams, with no timeout. Mask byte values other than 0/FF count as motion.
// STRUCTURE
// - Shared package motion_pkg: IMG_WIDTH, IMG_HEIGHT, NUM_PIXELS, typedef pixel_t (logic [31:0]),
//   typedef mask_t (logic [7:0]), HL_RED constant. motion_detect_top and this block both import it.
// - No sub-module. One always_ff holds the output register and counters; one always_comb holds accept and the
//   output strobes. No explicit FSM: state is out_valid plus pix_cnt.
// TESTING
// - Use a 4x2 image (WIDTH=4, HEIGHT=2) for directed cases and a full 720x540 regression.
// 1 mask=00 for all pixels, frame=32'h11223300, out_full=0 -> out_din=32'h11223300 one cycle after the pop;
//   frame_done pulses after pixel 8; motion_count=0.
// 2 Alternating mask FF/00 over a 4x2 frame -> even pixels=32'h0000FF00, odd pixels pass through;
//   motion_count=4.
// 3 out_full held high for 5 cycles mid-frame -> exactly one pixel is held; rd_en stays 0 while out_valid;
//   no loss or duplication; order preserved.
// 4 mask FIFO empty for 3 cycles while frame FIFO is non-empty -> neither FIFO is popped;
//   after resume, pixel pairing is still aligned.
// 5 Two back-to-back frames with 3 and 5 motion pixels -> two frame_done pulses exactly 8 writes apart;
//   motion_count=3, then 5.
// 6 Reset asserted after pixel 5 of a frame, then a full frame -> all outputs are 0 during reset;
//   the next frame_done comes after 8 writes.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared definitions for the motion-detect pipeline: image geometry, pixel/mask types,
// and the default highlight colour.
package motion_pkg;

    localparam int IMG_WIDTH  = 720;
    localparam int IMG_HEIGHT = 540;
    localparam int NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;

    typedef logic [31:0] pixel_t;   // {B,G,R,8'h00}
    typedef logic [7:0]  mask_t;    // nonzero = motion

    localparam pixel_t HL_RED = 32'h0000FF00;

    function automatic logic is_motion(input mask_t m);
        return |m;
    endfunction

endpackage

// File: rtl/motion_highlight.sv
// Joins the motion mask with the frame stream, replaces moving pixels by a highlight colour,
// and reports per-frame motion pixel counts to the output FIFO side.
module motion_highlight
    import motion_pkg::*;
#(
    parameter int     WIDTH    = IMG_WIDTH,
    parameter int     HEIGHT   = IMG_HEIGHT,
    parameter pixel_t HL_COLOR = HL_RED,
    parameter int     CNT_W    = 20
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mask_rd_en,
    input  mask_t            mask_dout,
    input  logic             mask_empty,
    output logic             frame_rd_en,
    input  pixel_t           frame_dout,
    input  logic             frame_empty,
    output logic             out_wr_en,
    output pixel_t           out_din,
    input  logic             out_full,
    output logic             frame_done,
    output logic [CNT_W-1:0] motion_count
);

    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(WIDTH * HEIGHT - 1);

    if ((2.0 ** CNT_W) <= (WIDTH * HEIGHT)) begin : g_cnt_w_check
        $error("CNT_W too small for WIDTH*HEIGHT");
    end

    logic             out_valid;
    logic             out_mask;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_inc;
    logic             accept;
    logic             last_pix;

    // Both FIFOs pop together so mask and pixel stay paired; a held output blocks new pops.
    always_comb begin
        out_wr_en   = out_valid & ~out_full;
        accept      = ~reset & ~mask_empty & ~frame_empty & (~out_valid | ~out_full);
        mask_rd_en  = accept;
        frame_rd_en = accept;
        last_pix    = (pix_cnt == LAST_PIX);
        run_inc     = run_cnt + {{(CNT_W-1){1'b0}}, out_mask};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_din      <= '0;
            out_mask     <= 1'b0;
            pix_cnt      <= '0;
            run_cnt      <= '0;
            motion_count <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (accept) begin
                out_din   <= is_motion(mask_dout) ? HL_COLOR : frame_dout;
                out_mask  <= is_motion(mask_dout);
                out_valid <= 1'b1;
            end else if (out_wr_en) begin
                out_valid <= 1'b0;
            end

            // Counters follow committed writes so back-pressure never skews the frame boundary.
            if (out_wr_en) begin
                if (last_pix) begin
                    pix_cnt      <= '0;
                    run_cnt      <= '0;
                    motion_count <= run_inc;
                    frame_done   <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + CNT_W'(1);
                    run_cnt <= run_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_motion_highlight.sv
// Directed bench for motion_highlight on a 4x2 image with queue-modelled FWFT input FIFOs.
module tb_motion_highlight;
    import motion_pkg::*;

    localparam int          W  = 4;
    localparam int          H  = 2;
    localparam int          CW = 20;
    localparam logic [31:0] HL = 32'h0000FF00;

    logic          clk = 1'b0;
    logic          reset;
    logic          mask_rd_en;
    logic [7:0]    mask_dout;
    logic          mask_empty;
    logic          frame_rd_en;
    logic [31:0]   frame_dout;
    logic          frame_empty;
    logic          out_wr_en;
    logic [31:0]   out_din;
    logic          out_full;
    logic          frame_done;
    logic [CW-1:0] motion_count;

    always #5 clk = ~clk;

    motion_highlight #(.WIDTH(W), .HEIGHT(H), .HL_COLOR(HL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .mask_rd_en(mask_rd_en), .mask_dout(mask_dout), .mask_empty(mask_empty),
        .frame_rd_en(frame_rd_en), .frame_dout(frame_dout), .frame_empty(frame_empty),
        .out_wr_en(out_wr_en), .out_din(out_din), .out_full(out_full),
        .frame_done(frame_done), .motion_count(motion_count)
    );

    logic [7:0]    mq[$];
    logic [31:0]   fq[$];
    logic [31:0]   wq[$];
    int            fd_at[$];
    logic [CW-1:0] mc_at[$];
    int            pop_cyc[$];
    int            wr_cyc[$];
    bit            mask_stall, frame_stall, full_stall;
    int            cyc;
    int            vectors;
    int            miscompares;

    // One clock: present FIFO heads at negedge, observe strobes, then apply the pops/writes
    // that the coming posedge will perform.
    task automatic step();
        @(negedge clk);
        mask_empty  = (mq.size() == 0) || mask_stall;
        mask_dout   = (mq.size() != 0) ? mq[0] : 8'h00;
        frame_empty = (fq.size() == 0) || frame_stall;
        frame_dout  = (fq.size() != 0) ? fq[0] : 32'h0;
        out_full    = full_stall;
        #1;
        cyc++;
        vectors++;
        if (mask_rd_en !== frame_rd_en) begin
            miscompares++;
            $display("FAIL rd_en_pair: mask_rd_en=%b frame_rd_en=%b at cycle %0d", mask_rd_en, frame_rd_en, cyc);
        end
        if (frame_done === 1'b1) begin
            fd_at.push_back(wq.size());
            mc_at.push_back(motion_count);
        end
        if (mask_rd_en === 1'b1 && mq.size() != 0) begin
            void'(mq.pop_front());
            pop_cyc.push_back(cyc);
        end
        if (frame_rd_en === 1'b1 && fq.size() != 0) void'(fq.pop_front());
        if (out_wr_en === 1'b1) begin
            wq.push_back(out_din);
            wr_cyc.push_back(cyc);
        end
    endtask

    task automatic run_until(input int n, input string name);
        int budget;
        budget = 200;
        while (wq.size() < n && budget > 0) begin
            step();
            budget--;
        end
        vectors++;
        if (wq.size() < n) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d writes, wanted %0d", name, wq.size(), n);
        end
        repeat (2) step();
    endtask

    task automatic clear_log();
        wq.delete(); fd_at.delete(); mc_at.delete(); pop_cyc.delete(); wr_cyc.delete();
        mask_stall = 0; frame_stall = 0; full_stall = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mask_empty = 1'b1; frame_empty = 1'b1; out_full = 1'b0;
        mask_dout = 8'h00; frame_dout = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({out_wr_en, out_din, frame_done, motion_count, mask_rd_en, frame_rd_en} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: wr=%b din=%h fd=%b mc=%0d rd=%b/%b", out_wr_en, out_din,
                     frame_done, motion_count, mask_rd_en, frame_rd_en);
        end
        reset = 1'b0;
        clear_log();
    endtask

    task automatic test_passthrough();
        clear_log();
        for (int i = 0; i < 8; i++) begin mq.push_back(8'h00); fq.push_back(32'h11223300); end
        run_until(8, "pass");
        for (int i = 0; i < wq.size(); i++) begin
            vectors++;
            if (wq[i] !== 32'h11223300) begin
                miscompares++;
                $display("FAIL pass_pix%0d: got %h want 11223300", i, wq[i]);
            end
        end
        vectors++;
        if (pop_cyc.size() == 0 || wr_cyc.size() == 0 || wr_cyc[0] - pop_cyc[0] != 1) begin
            miscompares++;
            $display("FAIL pass_latency: pops=%0d writes=%0d, want 1 cycle pop-to-write", pop_cyc.size(), wr_cyc.size());
        end
        vectors++;
        if (fd_at.size() != 1 || fd_at[0] != 8 || mc_at[0] !== 0) begin
            miscompares++;
            $display("FAIL pass_frame_done: pulses=%0d want 1 after write 8 with motion_count 0", fd_at.size());
        end
    endtask

    task automatic test_alternate();
        logic [31:0] exp_px [8];
        exp_px = '{32'h0000FF00, 32'hA1102000, 32'h0000FF00, 32'hA3102000,
                   32'h0000FF00, 32'hA5102000, 32'h0000FF00, 32'hA7102000};
        clear_log();
        for (int i = 0; i < 8; i++) begin
            mq.push_back((i % 2 == 0) ? 8'hFF : 8'h00);
            fq.push_back({8'hA0 + 8'(i), 8'h10, 8'h20, 8'h00});
        end
        run_until(8, "alt");
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            vectors++;
            if (wq[i] !== exp_px[i]) begin
                miscompares++;
                $display("FAIL alt_pix%0d: got %h want %h", i, wq[i], exp_px[i]);
            end
        end
        vectors++;
        if (motion_count !== 4) begin
            miscompares++;
            $display("FAIL alt_motion_count: got %0d want 4", motion_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0]  mk [8];
        logic [31:0] exp_px [8];
        int          held;
        mk     = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h01};
        exp_px = '{32'hB0000000, 32'h0000FF00, 32'hB2000000, 32'hB3000000,
                   32'h0000FF00, 32'hB5000000, 32'hB6000000, 32'h0000FF00};
        clear_log();
        for (int i = 0; i < 8; i++) begin mq.push_back(mk[i]); fq.push_back({8'hB0 + 8'(i), 24'h0}); end
        while (wq.size() < 3 && cyc < 100000) step();
        held = wq.size();
        full_stall = 1;
        for (int s = 0; s < 5; s++) begin
            step();
            vectors++;
            if (mask_rd_en !== 1'b0 || out_wr_en !== 1'b0 || wq.size() != held) begin
                miscompares++;
                $display("FAIL bp_hold%0d: rd=%b wr=%b writes=%0d want 0/0/%0d", s, mask_rd_en, out_wr_en, wq.size(), held);
            end
        end
        full_stall = 0;
        run_until(8, "bp");
        vectors++;
        if (wq.size() != 8) begin
            miscompares++;
            $display("FAIL bp_count: got %0d writes want 8", wq.size());
        end
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            vectors++;
            if (wq[i] !== exp_px[i]) begin
                miscompares++;
                $display("FAIL bp_pix%0d: got %h want %h", i, wq[i], exp_px[i]);
            end
        end
        vectors++;
        if (motion_count !== 3) begin
            miscompares++;
            $display("FAIL bp_motion_count: got %0d want 3", motion_count);
        end
    endtask

    task automatic test_mask_empty();
        logic [31:0] exp_px [8];
        exp_px = '{32'hC0000000, 32'hC1000000, 32'h0000FF00, 32'hC3000000,
                   32'hC4000000, 32'h0000FF00, 32'hC6000000, 32'hC7000000};
        clear_log();
        for (int i = 0; i < 8; i++) begin
            mq.push_back((i == 2 || i == 5) ? 8'hFF : 8'h00);
            fq.push_back({8'hC0 + 8'(i), 24'h0});
        end
        while (wq.size() < 2 && cyc < 100000) step();
        mask_stall = 1;
        for (int s = 0; s < 3; s++) begin
            step();
            vectors++;
            if (mask_rd_en !== 1'b0 || frame_rd_en !== 1'b0) begin
                miscompares++;
                $display("FAIL mempty_pop%0d: mask_rd_en=%b frame_rd_en=%b want 0/0", s, mask_rd_en, frame_rd_en);
            end
        end
        mask_stall = 0;
        run_until(8, "mempty");
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            vectors++;
            if (wq[i] !== exp_px[i]) begin
                miscompares++;
                $display("FAIL mempty_pix%0d: got %h want %h", i, wq[i], exp_px[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mk [16];
        mk = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF};
        clear_log();
        for (int i = 0; i < 16; i++) begin mq.push_back(mk[i]); fq.push_back({8'hD0 + 8'(i), 24'h0}); end
        run_until(16, "b2b");
        vectors++;
        if (fd_at.size() != 2 || fd_at[0] != 8 || fd_at[1] != 16) begin
            miscompares++;
            $display("FAIL b2b_pulses: got %0d pulses, want 2 after writes 8 and 16", fd_at.size());
        end
        vectors++;
        if (mc_at.size() != 2 || mc_at[0] !== 3 || mc_at[1] !== 5) begin
            miscompares++;
            $display("FAIL b2b_motion_count: got %0d entries, want 3 then 5", mc_at.size());
        end
        vectors++;
        if (wr_cyc.size() < 9 || wr_cyc[8] - wr_cyc[7] != 1) begin
            miscompares++;
            $display("FAIL b2b_gap: writes=%0d, want frame 2 first write in the cycle after frame 1 last", wr_cyc.size());
        end
    endtask

    task automatic test_reset_midframe();
        clear_log();
        for (int i = 0; i < 8; i++) begin mq.push_back(8'hFF); fq.push_back(32'hE0000000); end
        while (wq.size() < 5 && cyc < 100000) step();
        @(negedge clk);
        reset = 1'b1;
        mq.delete(); fq.delete();
        mask_empty = 1'b1; frame_empty = 1'b1;
        for (int s = 0; s < 2; s++) begin
            #1;
            vectors++;
            if ({out_wr_en, out_din, frame_done, motion_count, mask_rd_en, frame_rd_en} !== '0) begin
                miscompares++;
                $display("FAIL rst_mid%0d: wr=%b din=%h fd=%b mc=%0d rd=%b/%b", s, out_wr_en, out_din,
                         frame_done, motion_count, mask_rd_en, frame_rd_en);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        clear_log();
        for (int i = 0; i < 8; i++) begin
            mq.push_back((i < 2) ? 8'h40 : 8'h00);
            fq.push_back(32'hF0000000);
        end
        run_until(8, "rst");
        vectors++;
        if (fd_at.size() != 1 || fd_at[0] != 8 || mc_at[0] !== 2) begin
            miscompares++;
            $display("FAIL rst_frame_done: pulses=%0d want 1 after write 8 with motion_count 2", fd_at.size());
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        test_reset();
        test_passthrough();
        test_alternate();
        test_backpressure();
        test_mask_empty();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
